t1_watchdog_monitor: RTL and testbench

Synthesizable, DUT-side producer of the cosim watchdog status byte that the testbench clock driver polls once per cycle: 0 = continue, 255 = finished, anything else = fatal. The block tracks vector instruction issue and retire, counts the retire gap and total run cycles against configurable limits, and drains outstanding instructions before reporting completion. It sits between the T1 retire/issue probes and the DPI watchdog shim.

---
 rtl/t1_watchdog_pkg.sv | 10 +
 rtl/t1_watchdog_sat_counter.sv | 21 ++
 rtl/t1_watchdog_monitor.sv | 90 +++++++++
 tb/tb_t1_watchdog_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/t1_watchdog_pkg.sv
// t1_watchdog_pkg: state encoding and status byte values for the cosim watchdog monitor.
package t1_watchdog_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;
  localparam logic [7:0] ST_CONTINUE  = 8'd0;
  localparam logic [7:0] ST_DONE      = 8'd255;
  localparam logic [7:0] ST_GAP       = 8'd1;
  localparam logic [7:0] ST_GLOBAL    = 8'd2;
  localparam logic [7:0] ST_UNDERFLOW = 8'd3;
  localparam logic [7:0] ST_OVERFLOW  = 8'd4;
endpackage

// File: rtl/t1_watchdog_sat_counter.sv
// t1_watchdog_sat_counter: saturating counter with clear; hit_o flags the incremented value reaching a nonzero limit.
module t1_watchdog_sat_counter #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d, inc_v;
  assign inc_v = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign cnt_d = clr_i ? '0 : inc_i ? inc_v : cnt_q;
  assign hit_o = inc_i && !clr_i && limit_i != '0 && inc_v == limit_i;
  assign count_o = cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/t1_watchdog_monitor.sv
// t1_watchdog_monitor: cosim watchdog status byte (0 continue, 255 done, else fatal) from issue/retire tracking.
// Optional T1_WATCHDOG_DUMP_EN adds a cycle-windowed dump_on output.
module t1_watchdog_monitor
  import t1_watchdog_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int OUT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             issue_valid,
  input  logic             retire_valid,
  input  logic             quit_req,
  input  logic [CNT_W-1:0] gap_limit,
  input  logic [CNT_W-1:0] global_limit,
`ifdef T1_WATCHDOG_DUMP_EN
  input  logic [CNT_W-1:0] dump_start,
  input  logic [CNT_W-1:0] dump_end,
  output logic             dump_on,
`endif
  output logic [7:0]       status,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] gap,
  output logic [OUT_W-1:0] outstanding
);
  state_t state_q, state_d;
  logic [7:0] status_q, status_d, err;
  logic [OUT_W-1:0] out_q, out_d;
  logic active, inc, dec, uf, of, gap_hit, glb_hit, done;
  assign active = state_q == S_RUN || state_q == S_DRAIN;
  assign inc = issue_valid && !retire_valid;
  assign dec = retire_valid && !issue_valid;
  assign uf = active && dec && out_q == '0;
  assign of = active && inc && &out_q;
  assign out_d = !active ? out_q :
                 (dec && out_q != '0) ? out_q - 1'b1 :
                 (inc && !(&out_q)) ? out_q + 1'b1 : out_q;
  // A quit that still has work in flight goes through DRAIN instead of finishing directly
  assign done = state_q == S_RUN ? quit_req && out_q == '0 && !issue_valid
                                 : state_q == S_DRAIN && out_d == '0;
  assign err = uf ? ST_UNDERFLOW : of ? ST_OVERFLOW : gap_hit ? ST_GAP : glb_hit ? ST_GLOBAL : ST_CONTINUE;
  t1_watchdog_sat_counter #(.W(CNT_W)) u_gap (
    .clock(clock), .reset(reset), .clr_i(active && retire_valid), .inc_i(active),
    .limit_i(gap_limit), .count_o(gap), .hit_o(gap_hit)
  );
  t1_watchdog_sat_counter #(.W(CNT_W)) u_cycle (
    .clock(clock), .reset(reset), .clr_i(1'b0), .inc_i(active),
    .limit_i(global_limit), .count_o(cycle), .hit_o(glb_hit)
  );
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    if (state_q == S_IDLE && start) state_d = S_RUN;
    else if (active) begin
      if (err != ST_CONTINUE) begin
        state_d = S_ERR;
        status_d = err;
      end else if (done) begin
        state_d = S_DONE;
        status_d = ST_DONE;
      end else if (state_q == S_RUN && quit_req) state_d = S_DRAIN;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      status_q <= ST_CONTINUE;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      out_q <= out_d;
    end
  assign status = status_q;
  assign outstanding = out_q;
`ifdef T1_WATCHDOG_DUMP_EN
  logic dump_q, dump_d;
  logic [CNT_W-1:0] cyc_nxt;
  assign cyc_nxt = &cycle ? cycle : cycle + 1'b1;
  assign dump_d = state_q == S_IDLE ? dump_q || (start && dump_start == '0) :
                  !active ? dump_q :
                  (dump_end != '0 && cyc_nxt == dump_end) ? 1'b0 :
                  cyc_nxt == dump_start ? 1'b1 : dump_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) dump_q <= 1'b0;
    else dump_q <= dump_d;
  assign dump_on = dump_q;
`endif
endmodule

// File: tb/tb_t1_watchdog_monitor.sv
// tb_t1_watchdog_monitor: directed stimulus against a cycle-level behavioural model plus literal spot checks.
module tb_t1_watchdog_monitor;
  localparam int CW = 8;
  localparam int OW = 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAXO = (1 << OW) - 1;
  logic clock = 0, reset = 1;
  logic start = 0, issue_valid = 0, retire_valid = 0, quit_req = 0;
  logic [CW-1:0] gap_limit = 0, global_limit = 0, dump_start = 2, dump_end = 0;
  logic dump_on_w;
  logic [7:0] status;
  logic [CW-1:0] cycle, gap;
  logic [OW-1:0] outstanding;
  int total = 0, bad = 0;
  int m_mode, m_st, m_cyc, m_gap, m_out, m_dump;
  t1_watchdog_monitor #(.CNT_W(CW), .OUT_W(OW)) dut (
    .clock(clock), .reset(reset), .start(start), .issue_valid(issue_valid),
    .retire_valid(retire_valid), .quit_req(quit_req), .gap_limit(gap_limit),
    .global_limit(global_limit),
`ifdef T1_WATCHDOG_DUMP_EN
    .dump_start(dump_start), .dump_end(dump_end), .dump_on(dump_on_w),
`endif
    .status(status), .cycle(cycle), .gap(gap), .outstanding(outstanding)
  );
`ifndef T1_WATCHDOG_DUMP_EN
  assign dump_on_w = 1'b0;
`endif
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model modes: 0 idle, 1 run, 2 drain, 3 finished (done or error)
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_st = 0; m_cyc = 0; m_gap = 0; m_out = 0; m_dump = 0;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        if (dump_start == 0) m_dump = 1;
      end
    end else if (m_mode != 3) begin
      int nc, ng, no, e;
      bit fin;
      nc = m_cyc < MAXC ? m_cyc + 1 : MAXC;
      ng = retire_valid ? 0 : (m_gap < MAXC ? m_gap + 1 : MAXC);
      no = m_out + int'(issue_valid) - int'(retire_valid);
      if (no < 0) no = 0;
      if (no > MAXO) no = MAXO;
      e = 0;
      if (global_limit != 0 && nc == global_limit) e = 2;
      if (gap_limit != 0 && !retire_valid && ng == gap_limit) e = 1;
      if (issue_valid && !retire_valid && m_out == MAXO) e = 4;
      if (retire_valid && !issue_valid && m_out == 0) e = 3;
      fin = (m_mode == 1 && quit_req && m_out == 0 && !issue_valid) || (m_mode == 2 && no == 0);
      if (dump_end != 0 && nc == dump_end) m_dump = 0;
      else if (nc == dump_start) m_dump = 1;
      m_cyc = nc; m_gap = ng; m_out = no;
      if (e != 0) begin m_st = e; m_mode = 3; end
      else if (fin) begin m_st = 255; m_mode = 3; end
      else if (m_mode == 1 && quit_req) m_mode = 2;
    end
  end
  always @(posedge clock) begin
    #1;
    chk("status", status, m_st);
    chk("cycle", cycle, m_cyc);
    chk("gap", gap, m_gap);
    chk("outstanding", outstanding, m_out);
`ifdef T1_WATCHDOG_DUMP_EN
    chk("dump_on", dump_on_w, m_dump);
`endif
  end
  task automatic drive(input logic s, input logic i, input logic r, input logic q);
    start = s; issue_valid = i; retire_valid = r; quit_req = q;
    @(negedge clock);
    start = 0; issue_valid = 0; retire_valid = 0; quit_req = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clock);
    chk("reset_status", status, 0);
    chk("reset_out", outstanding, 0);
    reset = 0;
    drive(0, 1, 0, 1);
    chk("idle_ignores_issue", outstanding, 0);
    chk("idle_no_cycle", cycle, 0);
    drive(1, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0);
    chk("basic_out3", outstanding, 3);
    repeat (3) drive(0, 0, 1, 0);
    chk("basic_status0", status, 0);
    drive(0, 0, 0, 1);
    chk("basic_done", status, 255);
    chk("basic_out0", outstanding, 0);
    idle(2);
    chk("basic_frozen_cycle", cycle, 7);
    do_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    idle(4);
    drive(0, 0, 1, 0);
    chk("drain_status0", status, 0);
    chk("drain_out1", outstanding, 1);
    idle(1);
    drive(0, 0, 1, 0);
    chk("drain_done", status, 255);
    do_reset();
    gap_limit = 4;
    drive(1, 0, 0, 0);
    idle(3);
    chk("gap_pre", status, 0);
    idle(1);
    chk("gap_err", status, 1);
    chk("gap_val", gap, 4);
    idle(3);
    chk("gap_frozen", gap, 4);
    chk("gap_cycle_frozen", cycle, 4);
    do_reset();
    gap_limit = 0; global_limit = 10;
    drive(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) chk("glb_pre", status, 0);
      drive(0, k % 3 == 1, k % 3 == 0, 0);
    end
    chk("glb_err", status, 2);
    chk("glb_cycle", cycle, 10);
    idle(2);
    do_reset();
    gap_limit = 10;
    drive(1, 0, 0, 0);
    idle(10);
    chk("gap_beats_glb", status, 1);
    do_reset();
    gap_limit = 0; global_limit = 0;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("underflow", status, 3);
    do_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    chk("simul_out", outstanding, 1);
    chk("simul_ok", status, 0);
    repeat (6) drive(0, 1, 0, 0);
    chk("of_full", outstanding, 7);
    drive(0, 1, 0, 0);
    chk("overflow", status, 4);
    do_reset();
    drive(1, 0, 0, 0);
    idle(300);
    chk("sat_cycle", cycle, 255);
    chk("sat_gap", gap, 255);
    chk("sat_status", status, 0);
    do_reset();
    drive(1, 0, 0, 0);
    idle(1);
`ifdef T1_WATCHDOG_DUMP_EN
    chk("dump_low", dump_on_w, 0);
`endif
    drive(0, 1, 0, 0);
`ifdef T1_WATCHDOG_DUMP_EN
    chk("dump_high", dump_on_w, 1);
`endif
    drive(0, 0, 0, 1);
    idle(1);
    #2 reset = 1;
    #1;
    chk("areset_status", status, 0);
    chk("areset_cycle", cycle, 0);
    chk("areset_gap", gap, 0);
    chk("areset_out", outstanding, 0);
`ifdef T1_WATCHDOG_DUMP_EN
    chk("areset_dump", dump_on_w, 0);
`endif
    @(negedge clock);
    reset = 0;
    idle(2);
    chk("areset_idle", cycle, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
